// File: rtl/ms_ureg.sv
// rtl/ms_ureg.sv - universal register: clear/preset, enable, hold/load/shift/count with wrap flags
module ms_ureg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             prs,
  input  logic             ce,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_b,
  output logic             sout,
  output logic             tc,
  output logic             ovf
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_UP    = 3'b100;
  localparam logic [2:0] M_DOWN  = 3'b101;
  localparam logic [2:0] M_UPRLD = 3'b110;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             q_max;
  logic             q_zero;

  assign q_max  = &q;
  assign q_zero = ~|q;
  assign q_b    = ~q;

  // Next value for an enabled edge, with the wrap that the chosen mode would produce.
  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    case (mode)
      M_HOLD:  q_next = q;
      M_LOAD:  q_next = d;
      M_SHL:   q_next = {q[WIDTH-2:0], sin};
      M_SHR:   q_next = {sin, q[WIDTH-1:1]};
      M_UP: begin
        q_next   = q + ONE;
        ovf_next = q_max;
      end
      M_DOWN: begin
        q_next   = q - ONE;
        ovf_next = q_zero;
      end
      M_UPRLD: begin
        q_next   = q_max ? d : q + ONE;
        ovf_next = q_max;
      end
      default: q_next = q;
    endcase
  end

  // Storage with clear > preset > enable priority; ovf only pulses on an enabled wrap.
  always_ff @(posedge clk) begin
    if (clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (prs) begin
      q   <= PRESET_VAL;
      ovf <= 1'b0;
    end else if (!ce) begin
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

  // Terminal count looks at the current mode and contents only, so it is valid before ce rises.
  always_comb begin
    tc = 1'b0;
    if ((mode == M_UP || mode == M_UPRLD) && q_max) tc = 1'b1;
    if (mode == M_DOWN && q_zero)                   tc = 1'b1;
  end

  // Serial output presents the bit about to be shifted out.
  always_comb begin
    sout = 1'b0;
    if (mode == M_SHL) sout = q[WIDTH-1];
    if (mode == M_SHR) sout = q[0];
  end

endmodule

// File: tb/tb_ms_ureg.sv
// tb/tb_ms_ureg.sv - scoreboard bench for ms_ureg with directed and random stimulus
module tb_ms_ureg;

  localparam int W   = 8;
  localparam int MOD = 256;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         prs = 1'b0;
  logic         ce = 1'b0;
  logic [2:0]   mode = 3'd0;
  logic [W-1:0] d = '0;
  logic         sin = 1'b0;
  logic [W-1:0] q;
  logic [W-1:0] q_b;
  logic         sout;
  logic         tc;
  logic         ovf;

  int total = 0;
  int bad = 0;

  ms_ureg #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .prs(prs), .ce(ce), .mode(mode), .d(d), .sin(sin),
    .q(q), .q_b(q_b), .sout(sout), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    q;
    int    ovf;
    int    tc;
    int    sout;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // reference state
  int  m_q = 0;
  int  m_ovf = 0;
  bit  m_known = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: compare every presented cycle against the oldest expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.name, ".q"},    int'(q),    e.q);
      check({e.name, ".q_b"},  int'(q_b),  (MOD - 1) - e.q);
      check({e.name, ".ovf"},  int'(ovf),  e.ovf);
      check({e.name, ".tc"},   int'(tc),   e.tc);
      check({e.name, ".sout"}, int'(sout), e.sout);
    end
  end

  // apply one cycle of inputs, record expectations for the current cycle, advance the model
  task automatic step(input string name, input bit c, input bit p, input bit en,
                      input int md, input int dv, input bit s);
    exp_t x;
    int   nq;
    int   nov;
    @(posedge clk);
    #1;
    clr = c; prs = p; ce = en; mode = md[2:0]; d = dv[W-1:0]; sin = s;
    if (m_known) begin
      x.name = name;
      x.q    = m_q;
      x.ovf  = m_ovf;
      x.tc   = (((md == 4 || md == 6) && m_q == MOD - 1) || (md == 5 && m_q == 0)) ? 1 : 0;
      x.sout = (md == 2) ? m_q / (MOD / 2) : (md == 3) ? m_q % 2 : 0;
      sb.push_back(x);
    end
    nq = m_q;
    nov = 0;
    if (c) begin
      nq = 0;
    end else if (p) begin
      nq = MOD - 1;
    end else if (en) begin
      case (md)
        1: nq = dv % MOD;
        2: nq = (m_q * 2 + s) % MOD;
        3: nq = m_q / 2 + s * (MOD / 2);
        4: begin nq = (m_q + 1) % MOD; nov = (m_q == MOD - 1); end
        5: begin nq = (m_q + MOD - 1) % MOD; nov = (m_q == 0); end
        6: begin nq = (m_q == MOD - 1) ? dv % MOD : m_q + 1; nov = (m_q == MOD - 1); end
        default: nq = m_q;
      endcase
    end
    m_q = nq;
    m_ovf = nov;
    if (c) m_known = 1;
  endtask

  initial begin
    int guard;
    // 1: clear beats preset
    step("clr", 1, 1, 1, 4, 'h00, 0);
    step("clr_res", 0, 0, 0, 0, 'h00, 0);
    // 2: preset without enable, then wrap on UP
    step("prs", 0, 1, 0, 4, 'h00, 0);
    step("up_wrap", 0, 0, 1, 4, 'h00, 0);
    step("after_wrap", 0, 0, 0, 4, 'h00, 0);
    step("after_wrap2", 0, 0, 0, 0, 'h00, 0);
    // 3: load then shift left
    step("load_a5", 0, 0, 1, 1, 'hA5, 0);
    for (int i = 0; i < 3; i++) step("shl", 0, 0, 1, 2, 'h00, 1);
    step("shl_end", 0, 0, 0, 0, 'h00, 0);
    // shift right
    for (int i = 0; i < 3; i++) step("shr", 0, 0, 1, 3, 'h00, i[0]);
    // 4: load 01, count down through zero, then hold
    step("load_01", 0, 0, 1, 1, 'h01, 0);
    for (int i = 0; i < 2; i++) step("down", 0, 0, 1, 5, 'h00, 0);
    for (int i = 0; i < 5; i++) step("hold_ce0", 0, 0, 0, 5, 'h00, 0);
    // 5: reload counter and reserved mode
    step("load_fe", 0, 0, 1, 1, 'hFE, 0);
    for (int i = 0; i < 3; i++) step("uprld", 0, 0, 1, 6, 'hF0, 0);
    for (int i = 0; i < 2; i++) step("rsvd", 0, 0, 1, 7, 'h00, 0);
    // preset mid-count abandons the wrap
    step("pre_ff", 0, 1, 0, 0, 'h00, 0);
    step("prs_mid", 0, 1, 1, 4, 'h00, 0);
    step("prs_chk", 0, 0, 0, 0, 'h00, 0);
    // 6: random
    for (int i = 0; i < 10000; i++) begin
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 85), int'($urandom_range(0, 7)),
           (($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 'hFF : 'h00)
                                        : int'($urandom_range(0, 255))),
           $urandom_range(0, 1));
    end
    step("final", 0, 0, 0, 0, 'h00, 0);
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
